bus_arbiter: RTL and testbench

- Registered round-robin arbiter that shares one memory bus channel among NUM_REQ cache requesters (default: ICache = 0, DCache = 1).
- The top level instantiates it twice: once for the address/data request channel and once for the store-data channel.
- Each requester's abtr_reqcyc/abtr_grant/bus_busy triple connects to this block's req/grant/busy bit.
- Grant is held for the whole transaction and revoked on completion, abandonment or timeout.

---
 rtl/bus_arb_pkg.sv | 16 +
 rtl/bus_arbiter_picker.sv | 36 +++
 rtl/bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_bus_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and default constants for the round-robin bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANTED = 2'd1,
    ARB_HELD    = 2'd2
  } arb_state_t;

  localparam int ARB_NUM_REQ       = 2;
  localparam int ARB_GRANT_TIMEOUT = 16;

  localparam int REQ_ICACHE = 0;
  localparam int REQ_DCACHE = 1;

endpackage

// File: rtl/bus_arbiter_picker.sv
// Combinational round-robin pick: rotate req so the slot after last_owner is
// bit 0, take the lowest set bit, then rotate the index back.
module rr_priority_picker
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_owner_i,
  output logic [ID_W-1:0]    pick_o,
  output logic               pick_valid_o
);

  logic [ID_W-1:0]      start;
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [ID_W-1:0]      enc;
  logic [ID_W:0]        sum_raw;
  logic [ID_W:0]        sum_wrap;

  always_comb begin
    start = (last_owner_i == ID_W'(NUM_REQ - 1)) ? '0 : last_owner_i + ID_W'(1);
    dbl   = {req_i, req_i} >> start;
    rot   = dbl[NUM_REQ-1:0];
    enc   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) enc = ID_W'(i);
    end
    sum_raw  = {1'b0, start} + {1'b0, enc};
    sum_wrap = (sum_raw >= (ID_W+1)'(NUM_REQ)) ? sum_raw - (ID_W+1)'(NUM_REQ) : sum_raw;
    pick_o       = sum_wrap[ID_W-1:0];
    pick_valid_o = |req_i;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Registered round-robin arbiter for one memory bus channel. A grant is held
// through the requester's busy window and revoked on completion, abandonment or timeout.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ       = ARB_NUM_REQ,
  parameter int GRANT_TIMEOUT = ARB_GRANT_TIMEOUT,
  parameter int ID_W          = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] busy_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               owner_valid_o,
  output logic [ID_W-1:0]    owner_id_o,
  output logic               bus_busy_any_o,
  output logic               timeout_pulse_o,
  output logic               protocol_err_o,
  output arb_state_t         state_o
);

  localparam int CNT_W = $clog2(GRANT_TIMEOUT);

  // Handshake: req is a level held by the requester; grant answers one edge
  // later and stays up while busy from the owner is asserted; busy from anyone
  // else is a protocol error and never influences arbitration.

  arb_state_t           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ID_W-1:0]      last_q, last_d;
  logic [ID_W-1:0]      owner_q, owner_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 valid_q, valid_d;
  logic                 bba_q, bba_d;
  logic                 tp_q, tp_d;
  logic                 perr_q, perr_d;
  logic                 illegal_busy;
  logic [ID_W-1:0]      pick;
  logic                 pick_valid;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req_i        (req_i),
    .last_owner_i (last_q),
    .pick_o       (pick),
    .pick_valid_o (pick_valid)
  );

  always_comb begin
    illegal_busy = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (busy_i[i] && (state_q == ARB_IDLE || owner_q != ID_W'(i))) illegal_busy = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    owner_d = owner_q;
    grant_d = grant_q;
    valid_d = valid_q;
    tp_d    = 1'b0;
    perr_d  = perr_q | illegal_busy;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d       = ARB_GRANTED;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          owner_d       = pick;
          valid_d       = 1'b1;
          last_d        = pick;
          cnt_d         = '0;
        end
      end
      ARB_GRANTED: begin
        if (busy_i[owner_q]) begin
          state_d = ARB_HELD;
        end else if (!req_i[owner_q]) begin
          state_d = ARB_IDLE;
        end else if (cnt_q == CNT_W'(GRANT_TIMEOUT - 1)) begin
          state_d = ARB_IDLE;
          tp_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ARB_HELD: begin
        if (!busy_i[owner_q]) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase

    // Any transition back to IDLE drops the grant on this edge.
    if (state_q != ARB_IDLE && state_d == ARB_IDLE) begin
      grant_d = '0;
      valid_d = 1'b0;
      owner_d = '0;
      cnt_d   = '0;
    end

    bba_d = (state_d == ARB_HELD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
      owner_q <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      bba_q   <= 1'b0;
      tp_q    <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      bba_q   <= bba_d;
      tp_q    <= tp_d;
      perr_q  <= perr_d;
    end
  end

  assign grant_o         = grant_q;
  assign owner_valid_o   = valid_q;
  assign owner_id_o      = owner_q;
  assign bus_busy_any_o  = bba_q;
  assign timeout_pulse_o = tp_q;
  assign protocol_err_o  = perr_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed table, multi-cycle corner sequences and
// randomized traffic compared against a transaction-level reference model.
module tb_bus_arbiter;

  localparam int N  = 2;
  localparam int T  = 16;
  localparam int IW = 1;
  localparam int W  = N + IW + 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  busy = '0;
  logic [N-1:0]  grant;
  logic          owner_valid;
  logic [IW-1:0] owner_id;
  logic          bus_busy_any;
  logic          timeout_pulse;
  logic          protocol_err;
  bus_arb_pkg::arb_state_t dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model state: who owns the bus, whether the owner has started
  // using it, how many idle granted cycles have elapsed, and the last winner
  int m_owner;
  int m_last;
  int m_wait;
  bit m_inuse;
  bit m_tp;
  bit m_perr;

  bus_arbiter #(.NUM_REQ(N), .GRANT_TIMEOUT(T), .ID_W(IW)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_i           (req),
    .busy_i          (busy),
    .grant_o         (grant),
    .owner_valid_o   (owner_valid),
    .owner_id_o      (owner_id),
    .bus_busy_any_o  (bus_busy_any),
    .timeout_pulse_o (timeout_pulse),
    .protocol_err_o  (protocol_err),
    .state_o         (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] dut_vec();
    return {grant, owner_valid, owner_id, bus_busy_any, timeout_pulse, protocol_err};
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got=%b exp=%b", name, cyc, got, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] bz);
    if (r) begin
      m_owner = -1; m_inuse = 0; m_wait = 0; m_last = N - 1; m_tp = 0; m_perr = 0;
      return;
    end
    m_tp = 0;
    for (int i = 0; i < N; i++)
      if (bz[i] && (m_owner < 0 || i != m_owner)) m_perr = 1;
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_last + k) % N;
        if (rq[j]) begin
          m_owner = j; m_last = j; m_wait = 0; m_inuse = 0;
          break;
        end
      end
    end else if (m_inuse) begin
      if (!bz[m_owner]) begin m_owner = -1; m_inuse = 0; end
    end else if (bz[m_owner]) begin
      m_inuse = 1;
    end else if (!rq[m_owner]) begin
      m_owner = -1;
    end else if (m_wait == T - 1) begin
      m_owner = -1; m_tp = 1;
    end else begin
      m_wait++;
    end
  endtask

  function automatic logic [W-1:0] model_vec();
    logic [N-1:0]  g;
    logic [IW-1:0] id;
    g  = '0;
    id = '0;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      id = IW'(m_owner);
    end
    return {g, (m_owner >= 0), id, m_inuse, m_tp, m_perr};
  endfunction

  // one clock: apply inputs, advance the model on the edge, compare after it
  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] bz);
    reset = r; req = rq; busy = bz;
    @(posedge clk);
    model_step(r, rq, bz);
    #1;
    cyc++;
    check("model", dut_vec(), model_vec());
    check("invariant", W'($onehot0(grant) && ((grant != '0) == owner_valid)), W'(1));
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] rq;
    logic [N-1:0] bz;
    logic [N-1:0] g;
    logic         bba;
    logic         tp;
    logic         perr;
  } vec_t;

  vec_t tbl[20];
  logic [IW-1:0] exp_q[$];
  logic [IW-1:0] got_owner;

  initial begin
    // single transaction, abandon, illegal busy, reset while held
    tbl[0]  = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 2'b10, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 2'b01, 2'b10, 2'b01, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 2'b11, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 2'b11, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 2'b11, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 2'b11, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].rst, tbl[i].rq, tbl[i].bz);
      check($sformatf("table[%0d]", i), dut_vec(),
            {tbl[i].g, |tbl[i].g, IW'(tbl[i].g[1]), tbl[i].bba, tbl[i].tp, tbl[i].perr});
    end

    // contention: both requesting, nobody uses the bus, owners must alternate
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    step(1'b1, 2'b00, 2'b00);
    begin
      logic [N-1:0] prev;
      int seen;
      prev = '0;
      seen = 0;
      for (int c = 0; c < 80 && seen < 4; c++) begin
        step(1'b0, 2'b11, 2'b00);
        if (grant != '0 && prev != '0 && grant != prev)
          check("turnaround", W'(grant), W'(0));
        if (grant != '0 && prev == '0) begin
          got_owner = owner_id;
          check($sformatf("rr_order[%0d]", seen), W'(got_owner), W'(exp_q.pop_front()));
          seen++;
        end
        prev = grant;
      end
      check("rr_order_count", W'(seen), W'(4));
    end

    // timeout: requester 1 alone, never busy; grant lasts exactly T cycles
    step(1'b1, 2'b00, 2'b00);
    step(1'b0, 2'b10, 2'b00);
    check("timeout_first_grant", W'(grant), W'(2'b10));
    begin
      int held;
      bit dropped;
      held = (grant == 2'b10) ? 1 : 0;
      dropped = 0;
      for (int c = 0; c < 40; c++) begin
        step(1'b0, 2'b10, 2'b00);
        if (grant == 2'b10) held++;
        else begin
          dropped = 1;
          check("timeout_pulse_hi", W'(timeout_pulse), W'(1));
          break;
        end
      end
      check("timeout_dropped", W'(dropped), W'(1));
      check("timeout_len", W'(held), W'(T));
    end
    step(1'b0, 2'b11, 2'b00);
    check("after_timeout_grant", W'(grant), W'(2'b01));
    check("timeout_pulse_lo", W'(timeout_pulse), W'(0));

    // randomized traffic; the owner tends to use the bus, strays are rare
    step(1'b1, 2'b00, 2'b00);
    for (int c = 0; c < 3000; c++) begin
      logic         r;
      logic [N-1:0] rq;
      logic [N-1:0] bz;
      r  = ($urandom_range(0, 199) == 0);
      rq = N'($urandom_range(0, (1 << N) - 1));
      bz = '0;
      if (m_owner >= 0 && $urandom_range(0, 2) != 0) bz[m_owner] = 1'b1;
      if ($urandom_range(0, 79) == 0) bz[$urandom_range(0, N - 1)] = 1'b1;
      step(r, rq, bz);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
